// File: rtl/dac_pkg.sv
// Shared types and constants for the multi-channel sigma-delta / PWM DAC.
// Imported by the channel slice and the top level.
package dac_pkg;

  typedef enum logic {
    MODE_SD  = 1'b0,
    MODE_PWM = 1'b1
  } dac_mode_e;

  localparam int DATA_W_DEF = 8;
  localparam int N_CH_DEF   = 4;

  // Channel index width; a single channel still needs a 1-bit index port.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dac_sd_channel.sv
// One DAC channel: shadow/active code+mode, first-order sigma-delta
// accumulator or PWM comparator, and the registered output bit.
module dac_sd_channel
  import dac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_i,
  input  logic              frame_end_i,
  input  logic [DATA_W-1:0] cnt_next_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  dac_mode_e         wr_mode_i,
  output logic              bit_o
);

  logic [DATA_W-1:0] shadow_data_q, shadow_data_d;
  dac_mode_e         shadow_mode_q, shadow_mode_d;
  logic [DATA_W-1:0] active_data_q, active_data_d;
  dac_mode_e         active_mode_q, active_mode_d;
  logic [DATA_W-1:0] acc_q, acc_d, acc_base;
  logic [DATA_W:0]   sum;
  logic              bit_q, bit_d;

  // The output flop is computed from the counter value and active code that
  // will be current in the next cycle, so every frame (counter 0..2^W-1)
  // is produced entirely from one active code.
  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_mode_d = shadow_mode_q;
    active_data_d = active_data_q;
    active_mode_d = active_mode_q;
    acc_base      = acc_q;
    acc_d         = acc_q;
    bit_d         = 1'b0;

    if (wr_en_i) begin
      shadow_data_d = wr_data_i;
      shadow_mode_d = wr_mode_i;
    end

    if (frame_end_i) begin
      active_data_d = shadow_data_q;
      active_mode_d = shadow_mode_q;
      if (shadow_mode_q != active_mode_q) acc_base = '0;
    end

    sum = {1'b0, acc_base} + {1'b0, active_data_d};

    if (ena_i) begin
      if (active_mode_d == MODE_SD) begin
        acc_d = sum[DATA_W-1:0];
        bit_d = sum[DATA_W];
      end else begin
        acc_d = acc_base;
        bit_d = (cnt_next_i < active_data_d);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data_q <= '0;
      shadow_mode_q <= MODE_SD;
      active_data_q <= '0;
      active_mode_q <= MODE_SD;
      acc_q         <= '0;
      bit_q         <= 1'b0;
    end else begin
      shadow_data_q <= shadow_data_d;
      shadow_mode_q <= shadow_mode_d;
      active_data_q <= active_data_d;
      active_mode_q <= active_mode_d;
      acc_q         <= acc_d;
      bit_q         <= bit_d;
    end
  end

  assign bit_o = bit_q;

endmodule

// File: rtl/dac_sigma_delta_mc.sv
// Multi-channel 1-bit DAC: frame counter, write decode and error flag,
// with one dac_sd_channel per output bit.
module dac_sigma_delta_mc
  import dac_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int N_CH   = N_CH_DEF,
  localparam int CH_W   = ch_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_mode,
  output logic [N_CH-1:0]   bit_out,
  output logic              frame_strobe,
  output logic              wr_err
);

  // Handshake: a write transfers on a rising edge where wr_valid && wr_ready;
  // wr_ready simply mirrors ena, so writes are refused while the DAC is paused.
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              wr_err_q, wr_err_d;
  logic              wr_fire, wr_in_range, frame_end;

  assign wr_ready    = ena;
  assign wr_fire     = wr_valid & ena;
  assign wr_in_range = (int'(wr_ch) < N_CH);
  assign frame_end   = ena && (cnt_q == '1);

  always_comb begin
    cnt_d    = cnt_q;
    wr_err_d = wr_fire && !wr_in_range;
    if (ena) cnt_d = cnt_q + DATA_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_err_q <= wr_err_d;
    end
  end

  // rst_n gates the strobe so it is low throughout reset even though the
  // cleared counter reads zero.
  assign frame_strobe = ena && rst_n && (cnt_q == '0);
  assign wr_err       = wr_err_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr_en;
    assign wr_en = wr_fire && wr_in_range && (wr_ch == CH_W'(i));

    dac_sd_channel #(
      .DATA_W (DATA_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena_i       (ena),
      .frame_end_i (frame_end),
      .cnt_next_i  (cnt_d),
      .wr_en_i     (wr_en),
      .wr_data_i   (wr_data),
      .wr_mode_i   (dac_mode_e'(wr_mode)),
      .bit_o       (bit_out[i])
    );
  end

endmodule

// File: tb/tb_dac_sigma_delta_mc.sv
// Self-checking bench for dac_sigma_delta_mc: directed frame sequences, a
// vector table of per-frame one counts, and randomized traffic vs. a model.
module tb_dac_sigma_delta_mc;
  import dac_pkg::*;

  localparam int DW    = 8;
  localparam int NC    = 4;
  localparam int FRAME = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // clock/reset and main DUT stimulus
  logic       rst_n    = 1'b0;
  logic       ena      = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_ch    = '0;
  logic [7:0] wr_data  = '0;
  logic       wr_mode  = 1'b0;
  logic       wr_ready, frame_strobe, wr_err;
  logic [3:0] bit_out;

  // three-channel build for the out-of-range write
  logic       ena3      = 1'b1;
  logic       w3_valid  = 1'b0;
  logic [1:0] w3_ch     = '0;
  logic [7:0] w3_data   = '0;
  logic       w3_mode   = 1'b0;
  logic       wr_ready3, frame_strobe3, wr_err3;
  logic [2:0] bit_out3;

  dac_sigma_delta_mc #(.DATA_W(DW), .N_CH(NC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_data(wr_data), .wr_mode(wr_mode), .bit_out(bit_out),
    .frame_strobe(frame_strobe), .wr_err(wr_err)
  );

  dac_sigma_delta_mc #(.DATA_W(DW), .N_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena3), .wr_valid(w3_valid), .wr_ready(wr_ready3),
    .wr_ch(w3_ch), .wr_data(w3_data), .wr_mode(w3_mode), .bit_out(bit_out3),
    .frame_strobe(frame_strobe3), .wr_err(wr_err3)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position as an integer, per-channel running total
  // of applied codes; a sigma-delta one appears whenever the total crosses a
  // multiple of 2^DW.
  int         m_cnt;
  int         m_nxt;
  logic [7:0] m_sh_d [NC];
  logic       m_sh_m [NC];
  logic [7:0] m_act_d[NC];
  logic       m_act_m[NC];
  longint     m_tot  [NC];
  longint     m_old;
  logic [3:0] m_bit;
  logic       m_err;

  task automatic model_step();
    if (!rst_n) begin
      m_cnt = 0; m_bit = '0; m_err = 1'b0;
      for (int c = 0; c < NC; c++) begin
        m_sh_d[c] = '0; m_sh_m[c] = 1'b0; m_act_d[c] = '0; m_act_m[c] = 1'b0; m_tot[c] = 0;
      end
    end else begin
      m_err = wr_valid && ena && (int'(wr_ch) >= NC);
      if (ena) begin
        m_nxt = (m_cnt + 1) % FRAME;
        for (int c = 0; c < NC; c++) begin
          if (m_cnt == FRAME - 1) begin
            if (m_sh_m[c] != m_act_m[c]) m_tot[c] = 0;
            m_act_d[c] = m_sh_d[c];
            m_act_m[c] = m_sh_m[c];
          end
          if (m_act_m[c]) begin
            m_bit[c] = (m_nxt < int'(m_act_d[c]));
          end else begin
            m_old    = m_tot[c];
            m_tot[c] = m_tot[c] + longint'(m_act_d[c]);
            m_bit[c] = ((m_tot[c] / FRAME) != (m_old / FRAME));
          end
        end
        m_cnt = m_nxt;
      end else begin
        m_bit = '0;
      end
      if (wr_valid && ena && (int'(wr_ch) < NC)) begin
        m_sh_d[wr_ch] = wr_data;
        m_sh_m[wr_ch] = wr_mode;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic do_write(input logic [1:0] ch, input logic [7:0] d, input logic m);
    wr_valid = 1'b1; wr_ch = ch; wr_data = d; wr_mode = m;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    while (m_cnt != v && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (m_cnt != v) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_cnt: counter %0d never reached, now %0d", v, m_cnt);
    end
  endtask

  int cnt_ones[NC];
  task automatic count_frame();
    for (int c = 0; c < NC; c++) cnt_ones[c] = 0;
    for (int k = 0; k < FRAME; k++) begin
      for (int c = 0; c < NC; c++) cnt_ones[c] += int'(bit_out[c]);
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
    logic       mode;
    int         ones;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int e0, e1, ones0, strobes, n;

    tbl[0] = '{2'd0, 8'h40, 1'b0, 64};
    tbl[1] = '{2'd1, 8'h80, 1'b1, 128};
    tbl[2] = '{2'd2, 8'h00, 1'b0, 0};
    tbl[3] = '{2'd3, 8'hFF, 1'b1, 255};
    tbl[4] = '{2'd0, 8'hFF, 1'b0, 255};
    tbl[5] = '{2'd1, 8'h01, 1'b1, 1};
    tbl[6] = '{2'd2, 8'h10, 1'b0, 16};
    tbl[7] = '{2'd3, 8'h00, 1'b1, 0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_bits", 32'(bit_out), 0);
    check("rst_strobe", 32'(frame_strobe), 0);
    check("rst_err", 32'(wr_err), 0);
    check("rst_ready", 32'(wr_ready), 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    #1;
    check("ready_follows_ena", 32'(wr_ready), 1);
    @(negedge clk);

    // ch0 0x40 sigma-delta and ch1 0x80 PWM, checked in the second frame
    do_write(2'd0, 8'h40, 1'b0);
    do_write(2'd1, 8'h80, 1'b1);
    wait_cnt(0);
    count_frame();
    e0 = 0; e1 = 0; ones0 = 0; strobes = 0;
    for (int k = 0; k < FRAME; k++) begin
      e0      += int'(bit_out[0] != ((k % 4) == 3));
      e1      += int'(bit_out[1] != (k < 128));
      ones0   += int'(bit_out[0]);
      strobes += int'(frame_strobe) * ((k == 0) ? 1 : 100);
      @(negedge clk);
    end
    check("sd_every_4th", e0, 0);
    check("sd_ones_64", ones0, 64);
    check("pwm_half", e1, 0);
    check("strobe_once_at_0", strobes, 1);

    // write on the copy edge lands one frame later
    wait_cnt(FRAME - 1);
    do_write(2'd2, 8'h10, 1'b0);
    count_frame();
    check("copy_edge_frame1", cnt_ones[2], 0);
    count_frame();
    check("copy_edge_frame2", cnt_ones[2], 16);

    // pause at counter 100 for 10 cycles
    wait_cnt(100);
    ena = 1'b0;
    #1;
    check("pause_strobe_now", 32'(frame_strobe), 0);
    check("pause_ready", 32'(wr_ready), 0);
    e0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      e0 += int'(bit_out != 4'b0) + int'(frame_strobe);
    end
    check("pause_outputs_low", e0, 0);
    ena = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_strobe && n < 400);
    check("resume_strobe_after", n, 156);

    // vector table: ones per full frame
    for (int i = 0; i < 8; i++) begin
      wait_cnt(10);
      do_write(tbl[i].ch, tbl[i].data, tbl[i].mode);
      wait_cnt(0);
      count_frame();
      count_frame();
      check($sformatf("tbl%0d_ones", i), cnt_ones[tbl[i].ch], tbl[i].ones);
    end

    // out-of-range write on the three-channel build
    check("oor_err_idle", 32'(wr_err3), 0);
    w3_valid = 1'b1; w3_ch = 2'd3; w3_data = 8'hFF; w3_mode = 1'b1;
    @(negedge clk);
    w3_valid = 1'b0;
    check("oor_err_pulse", 32'(wr_err3), 1);
    @(negedge clk);
    check("oor_err_one_cycle", 32'(wr_err3), 0);
    e0 = 0;
    for (int k = 0; k < 2 * FRAME + 20; k++) begin
      e0 += int'(bit_out3 != 3'b0);
      @(negedge clk);
    end
    check("oor_no_channel_change", e0, 0);

    // mid-frame reset with all channels driving
    for (int c = 0; c < NC; c++) do_write(2'(c), 8'hFF, 1'b1);
    wait_cnt(0);
    wait_cnt(50);
    check("all_active", 32'(bit_out), 32'hF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bits", 32'(bit_out), 0);
    check("async_rst_strobe", 32'(frame_strobe), 0);
    check("async_rst_err", 32'(wr_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_frame();
    check("post_rst_frame_zero", cnt_ones[0] + cnt_ones[1] + cnt_ones[2] + cnt_ones[3], 0);

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      check("rand_bits", 32'(bit_out), 32'(m_bit));
      check("rand_strobe", 32'(frame_strobe), 32'((m_cnt == 0) && ena));
      check("rand_err", 32'(wr_err), 32'(m_err));
      check("rand_ready", 32'(wr_ready), 32'(ena));
      ena      = ($urandom_range(0, 19) != 0);
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_ch    = 2'($urandom_range(0, 3));
      wr_data  = 8'($urandom_range(0, 255));
      wr_mode  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_sigma_delta_mc.md
DAC_SIGMA_DELTA_MC -- requirements
Module: dac_sigma_delta_mc

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the sample width and the frame length of 2^DATA_W cycles.
REQ-002 Parameter N_CH, default 4, SHALL set the number of output channels; legal range 1..16.
REQ-003 Localparam CH_W SHALL equal max(1, clog2(N_CH)).
REQ-004 clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 ena  input  1  SHALL be the global run enable.
REQ-007 wr_valid  input  1  SHALL be the write request.
REQ-008 wr_ready  output  1  SHALL accept a write when high together with wr_valid.
REQ-009 wr_ch  input  CH_W  SHALL be the target channel index.
REQ-010 wr_data  input  DATA_W  SHALL be the sample code.
REQ-011 wr_mode  input  1  SHALL select the channel mode: 0 = sigma-delta, 1 = PWM.
REQ-012 bit_out  output  N_CH  SHALL carry one registered 1-bit DAC stream per channel, feeding the external RC filters.
REQ-013 frame_strobe  output  1  SHALL pulse for one cycle at the start of each frame.
REQ-014 wr_err  output  1  SHALL pulse for one cycle when an out-of-range write is accepted.

Function
REQ-015 wr_ready SHALL equal ena; a write is accepted on any edge where wr_valid and wr_ready are both high.
REQ-016 An accepted write with wr_ch < N_CH SHALL load {wr_data, wr_mode} into that channel's shadow register only.
REQ-017 An accepted write with wr_ch >= N_CH SHALL leave all channels unchanged and assert wr_err on the next cycle.
REQ-018 A DATA_W-bit frame counter SHALL increment by 1 per cycle while ena=1, wrapping from 2^DATA_W-1 to 0.
REQ-019 On the edge where the counter equals 2^DATA_W-1, every channel SHALL copy its shadow register (pre-edge value) into its active register.
REQ-020 A write accepted on the same edge as the REQ-019 copy SHALL update the shadow only; the new value SHALL take effect at the following frame.
REQ-021 frame_strobe SHALL be high during exactly those cycles in which the counter equals 0 and ena=1.
REQ-022 Sigma-delta mode: each cycle, compute sum = acc + active (DATA_W+1 bits); bit_out takes bit DATA_W of sum and acc takes sum[DATA_W-1:0], both registered.
REQ-023 Result of REQ-022: each full frame of a sigma-delta channel SHALL contain exactly active ones.
REQ-024 PWM mode: bit_out SHALL be registered (counter < active); code 0 gives constant 0 and code 2^DATA_W-1 gives 2^DATA_W-1 ones per frame.
REQ-025 When the active mode of a channel changes at a REQ-019 copy, that channel's acc SHALL be cleared to 0 on the same edge.
REQ-026 While ena=0:
- counter, acc and active registers SHALL hold;
- bit_out SHALL be 0 from the next edge;
- frame_strobe SHALL be 0.
REQ-027 When ena rises, operation SHALL resume from the held counter value without a frame restart.

Reset
REQ-028 While rst_n=0, the following SHALL be 0 immediately, independent of clk:
- counter, shadow registers, active registers and acc;
- bit_out, frame_strobe and wr_err.
REQ-029 The first frame after reset release SHALL output 0 on all channels; active registers are 0 until the first copy.
REQ-030 Reset asserted mid-frame SHALL abort that frame; no partial-frame state survives.

Structure
REQ-031 Package dac_pkg SHALL hold:
- the dac_mode_e typedef (MODE_SD=0, MODE_PWM=1);
- the DATA_W and N_CH default constants;
- the CH_W helper function.
REQ-032 Sub-module dac_sd_channel SHALL implement one channel (shadow, active, acc, mode mux, output flop) and be instantiated N_CH times by a generate loop.
REQ-033 The top level SHALL own the frame counter, write decode, wr_err and frame_strobe.

Verification (DATA_W=8, N_CH=4)
REQ-034 Write ch0 = 0x40 SD, then run two frames -> in the second frame, ch0 bit_out is high on every 4th cycle, for 64 ones total.
REQ-035 Write ch1 = 0x80 PWM -> next frame, ch1 bit_out is high for counter 0..127 and low for 128..255.
REQ-036 Write ch2 = 0x10 SD on the counter=255 edge -> ch2 stays 0 for the following frame and gives 16 ones the frame after.
REQ-037 Write wr_ch = 3 with N_CH = 3 (separate build) -> one-cycle wr_err pulse and no change on any bit_out.
REQ-038 Drop ena for 10 cycles at counter=100 -> bit_out = 0, frame_strobe = 0 and counter held at 100; after ena rises, frame_strobe occurs 156 cycles later.
REQ-039 Assert rst_n=0 mid-frame with all channels active -> all outputs 0 within the same cycle; after release, the first frame is all zeros.
